// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, PSR bit positions and FSM states shared by alu_seq and its multiplier.
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_LSH = 4'h6;
  localparam logic [3:0] OP_MUL = 4'h7;
  localparam int PSR_W = 5;
  localparam int PSR_C = 0;
  localparam int PSR_F = 1;
  localparam int PSR_L = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: start/done shift-add multiplier, one partial product per cycle over WIDTH cycles.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] acc_q, mc_q;
  logic [WIDTH-1:0]   mp_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  // prod is the accumulator after this cycle's step, so the final product is ready alongside done
  assign prod = acc_q + (mp_q[0] ? mc_q : '0);
  assign done = busy_q && cnt_q == CW'(1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      mc_q   <= '0;
      mp_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort) begin
      busy_q <= 1'b0;
    end else if (start) begin
      acc_q  <= '0;
      mc_q   <= {{WIDTH{1'b0}}, a};
      mp_q   <= b;
      cnt_q  <= CW'(WIDTH);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q  <= prod;
      mc_q   <= mc_q << 1;
      mp_q   <= mp_q >> 1;
      cnt_q  <= cnt_q - CW'(1);
      busy_q <= cnt_q != CW'(1);
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshake, registered result and PSR.
// Define ALU_SEQ_MUL_EN to enable the iterative MUL op; otherwise opcode 0111 is illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rsrc,
  input  logic [WIDTH-1:0] rdest,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_wr,
  output logic [PSR_W-1:0] psr,
  output logic             busy
);
  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d, result_q, result_d, sc_res, shifted;
  logic [PSR_W-1:0]   psr_q, psr_d, sc_psr;
  logic               dir_q, dir_d, wr_q, wr_d, sc_wr, accept;
  logic [WIDTH:0]     sum, diff;
  logic [SHAMT_W-1:0] amt;
  assign accept    = in_valid && state_q == IDLE;
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign result    = result_q;
  assign psr       = psr_q;
  assign result_wr = wr_q;
  assign sum       = {1'b0, rsrc} + {1'b0, rdest};
  assign diff      = {1'b0, rsrc} - {1'b0, rdest};
  assign amt       = rsrc[SHAMT_W-1:0];
  assign shifted   = dir_q ? work_q >> 1 : work_q << 1;
`ifdef ALU_SEQ_MUL_EN
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept && op == OP_MUL),
    .abort   (flush && state_q != IDLE),
    .a       (rsrc),
    .b       (rdest),
    .done    (mul_done),
    .prod    (mul_prod)
  );
`endif
  // Single-cycle ops; anything not listed (including LSH/MUL, handled by the FSM) is illegal here
  always_comb begin
    sc_res = '0;
    sc_psr = '0;
    sc_wr  = 1'b1;
    case (op)
      OP_ADD: begin
        sc_res        = sum[WIDTH-1:0];
        sc_psr[PSR_C] = sum[WIDTH];
        sc_psr[PSR_F] = rsrc[WIDTH-1] == rdest[WIDTH-1] && sum[WIDTH-1] != rsrc[WIDTH-1];
      end
      OP_SUB: begin
        sc_res        = diff[WIDTH-1:0];
        sc_psr[PSR_C] = diff[WIDTH];
        sc_psr[PSR_F] = rsrc[WIDTH-1] != rdest[WIDTH-1] && diff[WIDTH-1] != rsrc[WIDTH-1];
        sc_psr[PSR_L] = rdest < rsrc;
      end
      OP_AND: sc_res = rsrc & rdest;
      OP_XOR: sc_res = rsrc ^ rdest;
      OP_OR:  sc_res = rsrc | rdest;
      OP_CMP: begin
        sc_wr         = 1'b0;
        sc_res        = diff[WIDTH-1:0];
        sc_psr[PSR_Z] = rsrc == rdest;
        sc_psr[PSR_L] = rdest < rsrc;
        sc_psr[PSR_N] = $signed(rdest) < $signed(rsrc);
      end
      default: sc_wr = 1'b0;
    endcase
  end
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dir_d    = dir_q;
    result_d = result_q;
    psr_d    = psr_q;
    wr_d     = wr_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d = op;
        if (op == OP_LSH) begin
          work_d = rdest;
          cnt_d  = amt;
          dir_d  = rsrc[WIDTH-1];
          if (amt == '0) begin
            state_d  = DONE;
            result_d = rdest;
            psr_d    = '0;
            wr_d     = 1'b1;
          end else begin
            state_d = EXEC;
          end
`ifdef ALU_SEQ_MUL_EN
        end else if (op == OP_MUL) begin
          state_d = EXEC;
`endif
        end else begin
          state_d  = DONE;
          result_d = sc_res;
          psr_d    = sc_psr;
          wr_d     = sc_wr;
        end
      end
      EXEC: if (flush) begin
        state_d = IDLE;
      end else if (op_q == OP_LSH) begin
        work_d = shifted;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d  = DONE;
          result_d = shifted;
          psr_d    = '0;
          wr_d     = 1'b1;
        end
`ifdef ALU_SEQ_MUL_EN
      end else if (mul_done) begin
        state_d       = DONE;
        result_d      = mul_prod[WIDTH-1:0];
        psr_d         = '0;
        psr_d[PSR_C]  = |mul_prod[2*WIDTH-1:WIDTH];
        wr_d          = 1'b1;
`endif
      end
      DONE: state_d = flush || out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      work_q   <= '0;
      dir_q    <= 1'b0;
      result_q <= '0;
      psr_q    <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dir_q    <= dir_d;
      result_q <= result_d;
      psr_q    <= psr_d;
      wr_q     <= wr_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results, latencies and handshake behaviour.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'h0;
  logic [15:0] rsrc = '0;
  logic [15:0] rdest = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        result_wr;
  logic [4:0]  psr;
  logic        busy;
  int          n_chk = 0;
  int          n_fail = 0;
  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rsrc      (rsrc),
    .rdest     (rdest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_wr (result_wr),
    .psr       (psr),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // Presents one op and returns #1 after its accept edge with the inputs scrambled
  task automatic send(input logic [3:0] o, input logic [15:0] s, input logic [15:0] d);
    @(negedge clk);
    op = o; rsrc = s; rdest = d; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 4'hA; rsrc = 16'hDEAD; rdest = 16'hBEEF;
  endtask
  task automatic run(input logic [3:0] o, input logic [15:0] s, input logic [15:0] d, output int lat);
    send(o, s, d);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic take;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_after_take", {in_ready, out_valid}, 2'b10);
  endtask
  task automatic op_chk(input string tag, input logic [3:0] o, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] er, input logic [4:0] ep, input logic ew, input int elat);
    int lat;
    run(o, s, d, lat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_res"}, result, er);
    check({tag, "_psr"}, psr, ep);
    check({tag, "_wr"}, result_wr, ew);
    take();
  endtask
  initial begin
    #12;
    check("rst_outputs", {result, psr, result_wr, out_valid, busy}, '0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    op_chk("add", 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 5'b00010, 1'b1, 1);
    op_chk("illegal", 4'hF, 16'h1234, 16'h5678, 16'h0000, 5'b00000, 1'b0, 1);
    op_chk("sub", 4'h1, 16'h0001, 16'h0002, 16'hFFFF, 5'b00001, 1'b1, 1);
    op_chk("sub_l", 4'h1, 16'h0005, 16'h0003, 16'h0002, 5'b00100, 1'b1, 1);
    op_chk("cmp", 4'h5, 16'h0005, 16'h0003, 16'h0002, 5'b10100, 1'b0, 1);
    op_chk("cmp_eq", 4'h5, 16'h8000, 16'h8000, 16'h0000, 5'b01000, 1'b0, 1);
    op_chk("and", 4'h2, 16'hF0F0, 16'h3C3C, 16'h3030, 5'b00000, 1'b1, 1);
    op_chk("xor", 4'h3, 16'hF0F0, 16'h3C3C, 16'hCCCC, 5'b00000, 1'b1, 1);
    op_chk("or", 4'h4, 16'hF0F0, 16'h3C3C, 16'hFCFC, 5'b00000, 1'b1, 1);
    op_chk("lsh_left", 4'h6, 16'h0004, 16'h0001, 16'h0010, 5'b00000, 1'b1, 5);
    op_chk("lsh_right", 4'h6, 16'h8004, 16'h0080, 16'h0008, 5'b00000, 1'b1, 5);
    op_chk("lsh_zero", 4'h6, 16'h0000, 16'h1234, 16'h1234, 5'b00000, 1'b1, 1);
`ifdef ALU_SEQ_MUL_EN
    op_chk("mul", 4'h7, 16'h0012, 16'h0034, 16'h03A8, 5'b00000, 1'b1, 17);
    op_chk("mul_hi", 4'h7, 16'h0100, 16'h0100, 16'h0000, 5'b00001, 1'b1, 17);
`else
    op_chk("mul_off", 4'h7, 16'h0012, 16'h0034, 16'h0000, 5'b00000, 1'b0, 1);
`endif
    begin
      int lat;
      run(4'h1, 16'h0001, 16'h0002, lat);
      @(negedge clk);
      op = 4'h0; rsrc = 16'h0001; rdest = 16'h0001; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        #1;
        check("bp_hold", {out_valid, in_ready, result, psr}, {1'b1, 1'b0, 16'hFFFF, 5'b00001});
      end
      in_valid = 1'b0;
      take();
      @(posedge clk);
      #1;
      check("bp_no_accept", {out_valid, busy, result}, {1'b0, 1'b0, 16'hFFFF});
    end
    send(4'h6, 16'h000A, 16'h0001);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_lsh", {in_ready, out_valid, busy, psr, result}, {3'b100, 5'b00001, 16'hFFFF});
    repeat (12) @(posedge clk);
    #1;
    check("flush_lsh_quiet", {out_valid, in_ready}, 2'b01);
`ifdef ALU_SEQ_MUL_EN
    send(4'h7, 16'h0100, 16'h0100);
    repeat (7) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_mul", {in_ready, out_valid, psr}, {2'b10, 5'b00001});
    repeat (12) @(posedge clk);
    #1;
    check("flush_mul_quiet", {out_valid, in_ready}, 2'b01);
`endif
    begin
      int lat;
      run(4'h0, 16'h1234, 16'h1111, lat);
      check("post_flush_add", result, 16'h2345);
      flush = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_done", {in_ready, out_valid, psr}, {2'b10, 5'b00000});
    end
    send(4'h6, 16'h000A, 16'h0001);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_lsh", {result, psr, result_wr, out_valid, busy}, '0);
    check("rst_mid_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    op_chk("add_after_rst", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 5'b00001, 1'b1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
